rs_issue_queue: RTL and testbench
=================================

# rs_issue_queue

Parametrised reservation-station issue queue for the out-of-order core. It holds up to `RS_DEPTH` renamed instructions, captures operands from the common data bus (CDB), and each cycle issues the oldest ready instruction to each of `NUM_FU` functional units over a valid/ready handshake. It sits between rename/dispatch and the execution units and replaces single-entry, single-cycle issue with multi-entry, age-ordered, flushable issue.

## Interface
- `RS_DEPTH`, 8, number of entries (power of two, ≥2)
- `NUM_FU`, 3, number of functional units; FU index 0=ALU, 1=MUL, 2=MEM
- `TAG_W`, 6, rename tag width
- `DATA_W`, 32, operand width
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `flush`  in  1  synchronous squash of all entries and issue registers
- `alloc_valid`  in  1  dispatch offers an instruction
- `alloc_ready`  out  1  queue not full
- `alloc_op`  in  7  opcode (`op_type`)
- `alloc_fu`  in  $clog2(NUM_FU)  target FU index
- `alloc_dst_tag`  in  TAG_W  destination tag
- `alloc_srcN_rdy`, `alloc_srcN_tag`, `alloc_srcN_val` (N=1,2)  in  1 / TAG_W / DATA_W  operand ready flag, producer tag, value
- `cdb_valid`, `cdb_tag`, `cdb_data`  in  1 / TAG_W / DATA_W  result broadcast
- `iss_valid[NUM_FU]`  out  1 each  issue register occupied
- `iss_ready[NUM_FU]`  in  1 each  FU accepts
- `iss_op`, `iss_dst_tag`, `iss_src1`, `iss_src2` [NUM_FU]  out  7 / TAG_W / DATA_W / DATA_W
- `occupancy`  out  $clog2(RS_DEPTH)+1  valid entry count

## Operation
- Entry fields: valid, op, fu, dst_tag, per-source {rdy, tag, val}; plus NxN age matrix (`older[i][j]`=1 ⇔ j allocated before i).
- Allocate on `alloc_valid && alloc_ready`: write lowest-index free entry; its age row ← current valid vector; its column cleared in all rows.
- Wakeup: any valid entry source with `!rdy && tag==cdb_tag && cdb_valid` sets rdy, val←cdb_data. An allocating source with `!alloc_srcN_rdy` and tag matching a same-cycle CDB broadcast is written ready with cdb_data (bypass); no lost wakeups.
- Select, per FU f: candidates = valid && fu==f && src1.rdy && src2.rdy (registered flags; same-cycle CDB wakeup does not qualify). Pick candidate with no older candidate. Per-FU issue register loads the pick when `!iss_valid[f] || iss_ready[f]`; that entry's valid clears in the same edge.
- Handshake: `iss_valid[f]` and payload hold stable until `iss_ready[f]`; back-to-back issue with no bubble while `iss_ready` high.
- `alloc_ready` = occupancy < RS_DEPTH, from registered state only (a same-cycle issue does not free a slot for allocation).
- Flush: all entry valids, issue valids cleared at the edge; flush beats simultaneous alloc, issue and wakeup.
- Reset: identical to flush plus age matrix and all payload cleared to 0.
- Reset values: `alloc_ready`=1, `iss_valid`=0, all `iss_*` payload=0, `occupancy`=0.

## Timing
- Alloc with both sources ready at edge t → `iss_valid` high after edge t+1 (2-cycle minimum alloc-to-issue).
- CDB broadcast at edge t completing last operand → eligible for select in cycle after t, `iss_valid` after edge t+1.
- Full queue + issue at edge t → `alloc_ready` high after edge t.
- `iss_ready` low holds issue register; next-oldest candidate of that FU waits in the queue.
- Simultaneous alloc and wakeup of same tag, alloc and issue of different entries, and issue on all FUs in one cycle are all legal.

## Structure
- Package `rezzmaster`: `rs_entry_t` struct, FU index constants `FU_ALU`/`FU_MUL`/`FU_MEM`, `NUM_FU` default.
- Sub-module `rs_oldest_pick` (candidate vector + age matrix → one-hot grant, valid); instantiated once per FU.

## Test plan
- Reset → `alloc_ready`=1, `occupancy`=0, all `iss_valid`=0; alloc ALU op, both srcs ready, dst 0x05 → `iss_valid[0]` two cycles later, dst 0x05, `occupancy` back to 0.
- Alloc A (src1 tag 0x10 not ready) then B ready, both ALU → B issues first; CDB tag 0x10 data 0xDEAD → A issues with src1=0xDEAD two edges later.
- Alloc 3 ready ALU ops, `iss_ready[0]`=0 for 4 cycles → oldest held stable; then release → issue in allocation order, one per cycle.
- Fill 8 entries, all blocked on tag 0x20 → `alloc_ready`=0; CDB 0x20 → one issue per FU per cycle, `alloc_ready` returns after first drain.
- Alloc with src tag 0x11 in same cycle as CDB 0x11 data 0x42 → entry issues with src=0x42, no deadlock.
- Queue holding 5 entries plus occupied issue registers, assert `flush` with concurrent alloc → next cycle `occupancy`=0, all `iss_valid`=0, alloc dropped.

Source files
------------

// File: rtl/rezzmaster.sv
// rezzmaster: types and constants shared by the reservation-station issue
// queue and its oldest-first picker.
//   rs_src_t   : one source operand {rdy, producer tag, value}
//   rs_entry_t : one queue entry {valid, op, fu, dst_tag, src1, src2}
//   FU_ALU/FU_MUL/FU_MEM : functional-unit indices used on alloc_fu
package rezzmaster;

  localparam int NUM_FU_DEFAULT = 3;
  localparam int FU_IDX_W       = 2;
  localparam int RS_TAG_W       = 6;
  localparam int RS_DATA_W      = 32;

  typedef logic [6:0] op_type_t;

  localparam logic [FU_IDX_W-1:0] FU_ALU = 2'd0;
  localparam logic [FU_IDX_W-1:0] FU_MUL = 2'd1;
  localparam logic [FU_IDX_W-1:0] FU_MEM = 2'd2;

  typedef struct packed {
    logic                 rdy;
    logic [RS_TAG_W-1:0]  tag;
    logic [RS_DATA_W-1:0] val;
  } rs_src_t;

  typedef struct packed {
    logic                valid;
    op_type_t            op;
    logic [FU_IDX_W-1:0] fu;
    logic [RS_TAG_W-1:0] dst_tag;
    rs_src_t             src1;
    rs_src_t             src2;
  } rs_entry_t;

endpackage

// File: rtl/rs_oldest_pick.sv
// rs_oldest_pick: grants the oldest candidate entry.
//   cand_i  : candidate vector, one bit per queue entry
//   older_i : age matrix, older_i[i][j]=1 when entry j was allocated before i
//   grant_o : one-hot grant (all zero when no candidate)
//   valid_o : at least one candidate present
module rs_oldest_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0]        cand_i,
  input  logic [N-1:0][N-1:0] older_i,
  output logic [N-1:0]        grant_o,
  output logic                valid_o
);

  // The age matrix is a total order over live entries, so exactly one
  // candidate has no older candidate.
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < N; i++) begin
      grant_o[i] = cand_i[i] && ((older_i[i] & cand_i) == '0);
    end
  end

  assign valid_o = |cand_i;

endmodule

// File: rtl/rs_issue_queue.sv
// rs_issue_queue: age-ordered reservation station with CDB operand capture
// and one valid/ready issue register per functional unit.
//   clk_i, rst_i (sync, active-high), flush_i (squash entries + issue regs)
//   alloc_*_i / alloc_ready_o : dispatch interface, alloc_ready_o = not full
//   cdb_*_i                   : result broadcast used for wakeup and bypass
//   iss_*_o / iss_ready_i     : per-FU issue registers
//   occupancy_o               : number of valid entries
// TAG_W/DATA_W must match the widths of rezzmaster::rs_entry_t.
module rs_issue_queue
  import rezzmaster::*;
#(
  parameter int RS_DEPTH = 8,
  parameter int NUM_FU   = NUM_FU_DEFAULT,
  parameter int TAG_W    = RS_TAG_W,
  parameter int DATA_W   = RS_DATA_W
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic                               alloc_valid_i,
  output logic                               alloc_ready_o,
  input  op_type_t                           alloc_op_i,
  input  logic [$clog2(NUM_FU)-1:0]          alloc_fu_i,
  input  logic [TAG_W-1:0]                   alloc_dst_tag_i,
  input  logic                               alloc_src1_rdy_i,
  input  logic [TAG_W-1:0]                   alloc_src1_tag_i,
  input  logic [DATA_W-1:0]                  alloc_src1_val_i,
  input  logic                               alloc_src2_rdy_i,
  input  logic [TAG_W-1:0]                   alloc_src2_tag_i,
  input  logic [DATA_W-1:0]                  alloc_src2_val_i,
  input  logic                               cdb_valid_i,
  input  logic [TAG_W-1:0]                   cdb_tag_i,
  input  logic [DATA_W-1:0]                  cdb_data_i,
  output logic [NUM_FU-1:0]                  iss_valid_o,
  input  logic [NUM_FU-1:0]                  iss_ready_i,
  output logic [NUM_FU-1:0][6:0]             iss_op_o,
  output logic [NUM_FU-1:0][TAG_W-1:0]       iss_dst_tag_o,
  output logic [NUM_FU-1:0][DATA_W-1:0]      iss_src1_o,
  output logic [NUM_FU-1:0][DATA_W-1:0]      iss_src2_o,
  output logic [$clog2(RS_DEPTH):0]          occupancy_o
);

  localparam int OCC_W = $clog2(RS_DEPTH) + 1;

  rs_entry_t [RS_DEPTH-1:0]               ent_q, ent_d;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0]      older_q, older_d;
  logic [NUM_FU-1:0]                      iss_valid_q, iss_valid_d;
  logic [NUM_FU-1:0][6:0]                 iss_op_q, iss_op_d;
  logic [NUM_FU-1:0][TAG_W-1:0]           iss_dst_q, iss_dst_d;
  logic [NUM_FU-1:0][DATA_W-1:0]          iss_src1_q, iss_src1_d;
  logic [NUM_FU-1:0][DATA_W-1:0]          iss_src2_q, iss_src2_d;

  logic [RS_DEPTH-1:0]                    valid_vec, alloc_oh, issued;
  logic [NUM_FU-1:0][RS_DEPTH-1:0]        cand, grant;
  logic [NUM_FU-1:0]                      pick_valid, iss_load;
  logic                                   alloc_fire;
  rs_entry_t                              new_ent;

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < RS_DEPTH; i++) valid_vec[i] = ent_q[i].valid;
  end

  assign occupancy_o   = OCC_W'($countones(valid_vec));
  assign alloc_ready_o = ~&valid_vec;
  assign alloc_fire    = alloc_valid_i & alloc_ready_o;
  // lowest clear bit of valid_vec
  assign alloc_oh      = ~valid_vec & (valid_vec + RS_DEPTH'(1));

  // Select only looks at registered ready flags.
  always_comb begin
    cand = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        cand[f][i] = ent_q[i].valid && (ent_q[i].fu == FU_IDX_W'(f)) &&
                     ent_q[i].src1.rdy && ent_q[i].src2.rdy;
      end
    end
  end

  for (genvar f = 0; f < NUM_FU; f++) begin : g_pick
    rs_oldest_pick #(.N(RS_DEPTH)) u_pick (
      .cand_i  (cand[f]),
      .older_i (older_q),
      .grant_o (grant[f]),
      .valid_o (pick_valid[f])
    );
  end

  assign iss_load = ~iss_valid_q | iss_ready_i;

  always_comb begin
    issued = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      if (iss_load[f]) issued = issued | grant[f];
    end
  end

  // Incoming entry, with same-cycle CDB bypass so no wakeup is missed.
  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.op      = alloc_op_i;
    new_ent.fu      = alloc_fu_i;
    new_ent.dst_tag = alloc_dst_tag_i;
    new_ent.src1.tag = alloc_src1_tag_i;
    new_ent.src1.rdy = alloc_src1_rdy_i;
    new_ent.src1.val = alloc_src1_val_i;
    if (!alloc_src1_rdy_i && cdb_valid_i && alloc_src1_tag_i == cdb_tag_i) begin
      new_ent.src1.rdy = 1'b1;
      new_ent.src1.val = cdb_data_i;
    end
    new_ent.src2.tag = alloc_src2_tag_i;
    new_ent.src2.rdy = alloc_src2_rdy_i;
    new_ent.src2.val = alloc_src2_val_i;
    if (!alloc_src2_rdy_i && cdb_valid_i && alloc_src2_tag_i == cdb_tag_i) begin
      new_ent.src2.rdy = 1'b1;
      new_ent.src2.val = cdb_data_i;
    end
  end

  always_comb begin
    ent_d       = ent_q;
    older_d     = older_q;
    iss_valid_d = iss_valid_q;
    iss_op_d    = iss_op_q;
    iss_dst_d   = iss_dst_q;
    iss_src1_d  = iss_src1_q;
    iss_src2_d  = iss_src2_q;

    for (int i = 0; i < RS_DEPTH; i++) begin
      if (cdb_valid_i && ent_q[i].valid) begin
        if (!ent_q[i].src1.rdy && ent_q[i].src1.tag == cdb_tag_i) begin
          ent_d[i].src1.rdy = 1'b1;
          ent_d[i].src1.val = cdb_data_i;
        end
        if (!ent_q[i].src2.rdy && ent_q[i].src2.tag == cdb_tag_i) begin
          ent_d[i].src2.rdy = 1'b1;
          ent_d[i].src2.val = cdb_data_i;
        end
      end
      if (issued[i]) ent_d[i].valid = 1'b0;
      // The target slot is free in registered state, so it never collides
      // with an entry issuing this cycle.
      if (alloc_fire && alloc_oh[i]) begin
        ent_d[i]   = new_ent;
        older_d[i] = valid_vec;
      end
    end

    if (alloc_fire) begin
      for (int r = 0; r < RS_DEPTH; r++) older_d[r] = older_d[r] & ~alloc_oh;
    end

    for (int f = 0; f < NUM_FU; f++) begin
      if (iss_load[f]) begin
        iss_valid_d[f] = pick_valid[f];
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (grant[f][i]) begin
            iss_op_d[f]   = ent_q[i].op;
            iss_dst_d[f]  = ent_q[i].dst_tag;
            iss_src1_d[f] = ent_q[i].src1.val;
            iss_src2_d[f] = ent_q[i].src2.val;
          end
        end
      end
    end

    if (flush_i) begin
      for (int i = 0; i < RS_DEPTH; i++) ent_d[i].valid = 1'b0;
      iss_valid_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent_q       <= '0;
      older_q     <= '0;
      iss_valid_q <= '0;
      iss_op_q    <= '0;
      iss_dst_q   <= '0;
      iss_src1_q  <= '0;
      iss_src2_q  <= '0;
    end else begin
      ent_q       <= ent_d;
      older_q     <= older_d;
      iss_valid_q <= iss_valid_d;
      iss_op_q    <= iss_op_d;
      iss_dst_q   <= iss_dst_d;
      iss_src1_q  <= iss_src1_d;
      iss_src2_q  <= iss_src2_d;
    end
  end

  assign iss_valid_o   = iss_valid_q;
  assign iss_op_o      = iss_op_q;
  assign iss_dst_tag_o = iss_dst_q;
  assign iss_src1_o    = iss_src1_q;
  assign iss_src2_o    = iss_src2_q;

endmodule

// File: tb/tb_rs_issue_queue.sv
// tb_rs_issue_queue: directed scenarios followed by random traffic, every
// cycle compared against an in-order list model of the queue.
module tb_rs_issue_queue;
  import rezzmaster::*;

  localparam int D  = 8;
  localparam int NF = 3;

  logic              clk = 1'b0;
  logic              rst, flush, alloc_valid, alloc_ready;
  logic [6:0]        alloc_op;
  logic [1:0]        alloc_fu;
  logic [5:0]        alloc_dst, alloc_t1, alloc_t2;
  logic              alloc_r1, alloc_r2;
  logic [31:0]       alloc_v1, alloc_v2;
  logic              cdb_valid;
  logic [5:0]        cdb_tag;
  logic [31:0]       cdb_data;
  logic [NF-1:0]     iss_valid, iss_ready;
  logic [NF-1:0][6:0]  iss_op;
  logic [NF-1:0][5:0]  iss_dst;
  logic [NF-1:0][31:0] iss_src1, iss_src2;
  logic [3:0]        occupancy;

  always #5 clk = ~clk;

  rs_issue_queue #(.RS_DEPTH(D), .NUM_FU(NF), .TAG_W(6), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready),
    .alloc_op_i(alloc_op), .alloc_fu_i(alloc_fu), .alloc_dst_tag_i(alloc_dst),
    .alloc_src1_rdy_i(alloc_r1), .alloc_src1_tag_i(alloc_t1), .alloc_src1_val_i(alloc_v1),
    .alloc_src2_rdy_i(alloc_r2), .alloc_src2_tag_i(alloc_t2), .alloc_src2_val_i(alloc_v2),
    .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
    .iss_valid_o(iss_valid), .iss_ready_i(iss_ready),
    .iss_op_o(iss_op), .iss_dst_tag_o(iss_dst),
    .iss_src1_o(iss_src1), .iss_src2_o(iss_src2),
    .occupancy_o(occupancy)
  );

  // Reference model: live entries kept oldest-first in a queue.
  typedef struct {
    logic [6:0]  op;
    int          fu;
    logic [5:0]  dst;
    logic        r1;
    logic [5:0]  t1;
    logic [31:0] v1;
    logic        r2;
    logic [5:0]  t2;
    logic [31:0] v2;
  } ment_t;

  ment_t       mq[$];
  logic        m_iv  [NF];
  logic [6:0]  m_op  [NF];
  logic [5:0]  m_dst [NF];
  logic [31:0] m_s1  [NF];
  logic [31:0] m_s2  [NF];

  int checks = 0;
  int failures = 0;

  function automatic void model_step();
    ment_t nq[$];
    ment_t e;
    int    pick[NF];
    bit    acc, taken;
    if (rst) begin
      mq.delete();
      for (int f = 0; f < NF; f++) begin
        m_iv[f] = 1'b0; m_op[f] = '0; m_dst[f] = '0; m_s1[f] = '0; m_s2[f] = '0;
      end
      return;
    end
    acc = alloc_valid && (mq.size() < D);
    for (int f = 0; f < NF; f++) begin
      pick[f] = -1;
      if (!m_iv[f] || iss_ready[f]) begin
        for (int k = 0; k < mq.size(); k++) begin
          if (mq[k].fu == f && mq[k].r1 && mq[k].r2) begin
            pick[f] = k;
            break;
          end
        end
        m_iv[f] = (pick[f] >= 0);
        if (pick[f] >= 0) begin
          m_op[f]  = mq[pick[f]].op;
          m_dst[f] = mq[pick[f]].dst;
          m_s1[f]  = mq[pick[f]].v1;
          m_s2[f]  = mq[pick[f]].v2;
        end
      end
    end
    for (int k = 0; k < mq.size(); k++) begin
      taken = 1'b0;
      for (int f = 0; f < NF; f++) if (pick[f] == k) taken = 1'b1;
      if (!taken) begin
        e = mq[k];
        if (cdb_valid && !e.r1 && e.t1 == cdb_tag) begin e.r1 = 1'b1; e.v1 = cdb_data; end
        if (cdb_valid && !e.r2 && e.t2 == cdb_tag) begin e.r2 = 1'b1; e.v2 = cdb_data; end
        nq.push_back(e);
      end
    end
    if (acc) begin
      e.op = alloc_op; e.fu = int'(alloc_fu); e.dst = alloc_dst;
      e.r1 = alloc_r1; e.t1 = alloc_t1; e.v1 = alloc_v1;
      e.r2 = alloc_r2; e.t2 = alloc_t2; e.v2 = alloc_v2;
      if (!alloc_r1 && cdb_valid && alloc_t1 == cdb_tag) begin e.r1 = 1'b1; e.v1 = cdb_data; end
      if (!alloc_r2 && cdb_valid && alloc_t2 == cdb_tag) begin e.r2 = 1'b1; e.v2 = cdb_data; end
      nq.push_back(e);
    end
    if (flush) begin
      nq.delete();
      for (int f = 0; f < NF; f++) m_iv[f] = 1'b0;
    end
    mq = nq;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("alloc_ready", 64'(alloc_ready), 64'(mq.size() < D));
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    for (int f = 0; f < NF; f++) begin
      chk($sformatf("iss_valid[%0d]", f), 64'(iss_valid[f]), 64'(m_iv[f]));
      if (m_iv[f]) begin
        chk($sformatf("iss_op[%0d]", f),   64'(iss_op[f]),   64'(m_op[f]));
        chk($sformatf("iss_dst[%0d]", f),  64'(iss_dst[f]),  64'(m_dst[f]));
        chk($sformatf("iss_src1[%0d]", f), 64'(iss_src1[f]), 64'(m_s1[f]));
        chk($sformatf("iss_src2[%0d]", f), 64'(iss_src2[f]), 64'(m_s2[f]));
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic alloc_set(input logic [6:0] op, input int fu, input logic [5:0] dst,
                           input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                           input logic r2, input logic [5:0] t2, input logic [31:0] v2);
    alloc_valid = 1'b1; alloc_op = op; alloc_fu = 2'(fu); alloc_dst = dst;
    alloc_r1 = r1; alloc_t1 = t1; alloc_v1 = v1;
    alloc_r2 = r2; alloc_t2 = t2; alloc_v2 = v2;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0;
    alloc_op = '0; alloc_fu = '0; alloc_dst = '0;
    alloc_r1 = 1'b0; alloc_t1 = '0; alloc_v1 = '0;
    alloc_r2 = 1'b0; alloc_t2 = '0; alloc_v2 = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    iss_ready = '1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_iss_op", 64'(iss_op), 64'd0);
    chk("rst_iss_dst", 64'(iss_dst), 64'd0);
    chk("rst_iss_src_any", 64'(|{iss_src1, iss_src2}), 64'd0);

    // single ready ALU op: issue two edges after allocation
    alloc_set(7'h01, int'(FU_ALU), 6'h05, 1'b1, 6'h0, 32'h11, 1'b1, 6'h0, 32'h22);
    cycle();
    alloc_valid = 1'b0;
    cycle();
    chk("t1_iss_valid", 64'(iss_valid[0]), 64'd1);
    chk("t1_iss_dst", 64'(iss_dst[0]), 64'h05);
    chk("t1_occupancy", 64'(occupancy), 64'd0);
    cycle();

    // older blocked entry overtaken by younger ready one, then woken by CDB
    alloc_set(7'h02, int'(FU_ALU), 6'h0A, 1'b0, 6'h10, 32'h0, 1'b1, 6'h0, 32'h5);
    cycle();
    alloc_set(7'h03, int'(FU_ALU), 6'h0B, 1'b1, 6'h0, 32'h7, 1'b1, 6'h0, 32'h8);
    cycle();
    alloc_valid = 1'b0;
    cycle();
    chk("t2_first_dst", 64'(iss_dst[0]), 64'h0B);
    cdb_valid = 1'b1; cdb_tag = 6'h10; cdb_data = 32'hDEAD;
    cycle();
    cdb_valid = 1'b0;
    cycle();
    chk("t2_wake_valid", 64'(iss_valid[0]), 64'd1);
    chk("t2_wake_dst", 64'(iss_dst[0]), 64'h0A);
    chk("t2_wake_src1", 64'(iss_src1[0]), 64'hDEAD);
    cycle();

    // back-pressure on ALU: oldest held, then in-order drain
    iss_ready = 3'b110;
    for (int k = 0; k < 3; k++) begin
      alloc_set(7'(16 + k), int'(FU_ALU), 6'(48 + k), 1'b1, 6'h0, 32'(k), 1'b1, 6'h0, 32'(100 + k));
      cycle();
    end
    alloc_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t3_hold_dst", 64'(iss_dst[0]), 64'h30);
    end
    iss_ready = '1;
    cycle();
    chk("t3_second_dst", 64'(iss_dst[0]), 64'h31);
    cycle();
    chk("t3_third_dst", 64'(iss_dst[0]), 64'h32);
    cycle();

    // fill to capacity, all waiting on tag 0x20
    for (int k = 0; k < 8; k++) begin
      alloc_set(7'(32 + k), k % 3, 6'(k), 1'b0, 6'h20, 32'h0, 1'b1, 6'h0, 32'(k));
      cycle();
    end
    chk("t4_full_ready", 64'(alloc_ready), 64'd0);
    chk("t4_full_occ", 64'(occupancy), 64'd8);
    alloc_set(7'h7F, int'(FU_ALU), 6'h3F, 1'b1, 6'h0, 32'h1, 1'b1, 6'h0, 32'h2);
    cycle();
    chk("t4_drop_occ", 64'(occupancy), 64'd8);
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 6'h20; cdb_data = 32'hBEEF;
    cycle();
    cdb_valid = 1'b0;
    cycle();
    chk("t4_first_drain_occ", 64'(occupancy), 64'd5);
    chk("t4_first_drain_ready", 64'(alloc_ready), 64'd1);
    chk("t4_all_fu_issue", 64'(iss_valid), 64'h7);
    chk("t4_src1_beef", 64'(iss_src1[0]), 64'hBEEF);
    for (int k = 0; k < 4; k++) cycle();

    // allocation racing the CDB broadcast of its own source tag
    alloc_set(7'h44, int'(FU_MUL), 6'h15, 1'b0, 6'h11, 32'h0, 1'b1, 6'h0, 32'h9);
    cdb_valid = 1'b1; cdb_tag = 6'h11; cdb_data = 32'h42;
    cycle();
    alloc_valid = 1'b0; cdb_valid = 1'b0;
    cycle();
    chk("t5_bypass_valid", 64'(iss_valid[1]), 64'd1);
    chk("t5_bypass_src1", 64'(iss_src1[1]), 64'h42);
    cycle();

    // flush with occupied issue registers and a concurrent allocation
    iss_ready = '0;
    for (int k = 0; k < 8; k++) begin
      alloc_set(7'(64 + k), k % 3, 6'(56 + k), 1'b1, 6'h0, 32'(k), 1'b1, 6'h0, 32'(k));
      cycle();
    end
    chk("t6_pre_occ", 64'(occupancy), 64'd5);
    chk("t6_pre_iss", 64'(iss_valid), 64'h7);
    alloc_set(7'h55, int'(FU_MEM), 6'h2A, 1'b1, 6'h0, 32'h3, 1'b1, 6'h0, 32'h4);
    flush = 1'b1;
    cycle();
    chk("t6_flush_occ", 64'(occupancy), 64'd0);
    chk("t6_flush_iss", 64'(iss_valid), 64'd0);
    flush = 1'b0; alloc_valid = 1'b0; iss_ready = '1;
    cycle();
    chk("t6_alloc_dropped", 64'(occupancy), 64'd0);

    // random traffic
    for (int n = 0; n < 800; n++) begin
      alloc_valid = ($urandom_range(0, 3) != 0);
      alloc_op  = 7'($urandom);
      alloc_fu  = 2'($urandom_range(0, 2));
      alloc_dst = 6'($urandom);
      alloc_r1  = ($urandom_range(0, 2) == 0);
      alloc_t1  = 6'($urandom_range(0, 7));
      alloc_v1  = $urandom;
      alloc_r2  = ($urandom_range(0, 2) == 0);
      alloc_t2  = 6'($urandom_range(0, 7));
      alloc_v2  = $urandom;
      cdb_valid = ($urandom_range(0, 1) == 1);
      cdb_tag   = 6'($urandom_range(0, 7));
      cdb_data  = $urandom;
      iss_ready = 3'($urandom);
      flush     = ($urandom_range(0, 63) == 0);
      cycle();
    end
    alloc_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0; iss_ready = '1;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
